// File: rtl/srca_pkg.sv
// Shared cell models and cell-placement helpers for the segmented ripple-carry adder.
// Full-adder functions return {co, s}.
package srca_pkg;

    typedef enum logic {
        CELL_EXACT = 1'b0,
        CELL_APX   = 1'b1
    } cell_t;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [1:0] fa_exact(input logic x, input logic y, input logic ci);
        return {maj(x, y, ci), x ^ y ^ ci};
    endfunction

    // Carry stays exact; the sum is only wrong when x == y == ci.
    function automatic logic [1:0] fa_apx(input logic x, input logic y, input logic ci);
        logic co;
        co = maj(x, y, ci);
        return {co, ~co};
    endfunction

    function automatic logic is_apx_cell(input int unsigned i, input int unsigned blk,
                                         input int unsigned apx);
        return (i % blk) < apx;
    endfunction

    function automatic cell_t cell_kind(input int unsigned i, input int unsigned blk,
                                        input int unsigned apx);
        return is_apx_cell(i, blk, apx) ? CELL_APX : CELL_EXACT;
    endfunction

endpackage

// File: rtl/srca_seg.sv
// Combinational ripple segment of BPS blocks of BLK cells each; the low APX cells of
// every block switch to the approximate adder while approx_en is high.
module srca_seg
    import srca_pkg::*;
#(
    parameter int unsigned BLK = 2,
    parameter int unsigned APX = 1,
    parameter int unsigned BPS = 1
) (
    input  logic [BPS*BLK-1:0] a,
    input  logic [BPS*BLK-1:0] b,
    input  logic               ci,
    input  logic               approx_en,
    output logic [BPS*BLK-1:0] s,
    output logic               co
);

    localparam int unsigned N = BPS * BLK;

    logic [N:0] c;

    assign c[0] = ci;

    // Segments always start on a block boundary, so the local index gives the block position.
    for (genvar i = 0; i < N; i++) begin : g_cell
        localparam cell_t KIND = cell_kind(i, BLK, APX);
        logic [1:0] r;

        if (KIND == CELL_APX) begin : g_apx
            assign r = approx_en ? fa_apx(a[i], b[i], c[i]) : fa_exact(a[i], b[i], c[i]);
        end else begin : g_exact
            assign r = fa_exact(a[i], b[i], c[i]);
        end

        assign c[i+1] = r[1];
        assign s[i]   = r[0];
    end

    assign co = c[N];

endmodule

// File: rtl/srca_pipe.sv
// Pipelined segmented ripple-carry adder: STAGES register stages, each resolving one carry
// segment, with a single global stall driven by the output handshake.
module srca_pipe
    import srca_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned BLK    = 2,
    parameter int unsigned APX    = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_apx
);

    localparam int unsigned NBLK = WIDTH / BLK;
    localparam int unsigned BPS  = NBLK / STAGES;
    localparam int unsigned SEGW = BPS * BLK;

    if (STAGES == 0 || (WIDTH % BLK) != 0 || APX > BLK || STAGES > NBLK ||
        (NBLK % STAGES) != 0) begin : g_bad_params
        $error("srca_pipe: illegal WIDTH/BLK/APX/STAGES combination");
    end

    logic adv;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int unsigned LOW = (k + 1) * SEGW;
        localparam int unsigned REM = WIDTH - LOW;

        logic [SEGW-1:0] seg_a;
        logic [SEGW-1:0] seg_b;
        logic [SEGW-1:0] seg_s;
        logic            seg_ci;
        logic            seg_co;
        logic            seg_apx;
        logic            v_in;
        logic [LOW-1:0]  sum_next;
        logic [LOW-1:0]  sum_q;
        logic            v_q;
        logic            co_q;
        logic            apx_q;

        if (k == 0) begin : g_src
            assign seg_a    = a[SEGW-1:0];
            assign seg_b    = b[SEGW-1:0];
            assign seg_ci   = cin;
            assign seg_apx  = approx_en;
            assign v_in     = in_valid;
            assign sum_next = seg_s;
        end else begin : g_src
            assign seg_a    = stg[k-1].g_ops.a_q[SEGW-1:0];
            assign seg_b    = stg[k-1].g_ops.b_q[SEGW-1:0];
            assign seg_ci   = stg[k-1].co_q;
            assign seg_apx  = stg[k-1].apx_q;
            assign v_in     = stg[k-1].v_q;
            assign sum_next = {seg_s, stg[k-1].sum_q};
        end

        srca_seg #(
            .BLK(BLK),
            .APX(APX),
            .BPS(BPS)
        ) u_seg (
            .a        (seg_a),
            .b        (seg_b),
            .ci       (seg_ci),
            .approx_en(seg_apx),
            .s        (seg_s),
            .co       (seg_co)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
            end
        end

        // Datapath loads only with a valid transaction so outputs hold across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                co_q  <= 1'b0;
                apx_q <= 1'b0;
            end else if (adv && v_in) begin
                sum_q <= sum_next;
                co_q  <= seg_co;
                apx_q <= seg_apx;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [REM-1:0] fwd_a;
            logic [REM-1:0] fwd_b;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            if (k == 0) begin : g_fwd
                assign fwd_a = a[WIDTH-1:LOW];
                assign fwd_b = b[WIDTH-1:LOW];
            end else begin : g_fwd
                assign fwd_a = stg[k-1].g_ops.a_q[REM+SEGW-1:SEGW];
                assign fwd_b = stg[k-1].g_ops.b_q[REM+SEGW-1:SEGW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_in) begin
                    a_q <= fwd_a;
                    b_q <= fwd_b;
                end
            end
        end
    end

    assign in_ready  = ~stg[STAGES-1].v_q | out_ready;
    assign adv       = in_ready;
    assign out_valid = stg[STAGES-1].v_q;
    assign sum       = stg[STAGES-1].sum_q;
    assign cout      = stg[STAGES-1].co_q;
    assign out_apx   = stg[STAGES-1].apx_q;

endmodule
